// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad emulator: plays commanded key presses with contact bounce
// back onto the column lines of a row-scanned matrix.
module keypad_matrix_emulator #(
   parameter int unsigned MS_CYC       = 50000,
   parameter int unsigned BOUNCE_CYC   = 25000,
   parameter int unsigned BOUNCE_EDGES = 4,
   parameter int unsigned GAP_CYC      = 500000
) (
   input  logic       clk,
   input  logic       RST,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_key,
   input  logic [7:0] cmd_hold_ms,
   output logic       busy,
   output logic       done
);

   localparam int EW = (BOUNCE_EDGES > 1) ? $clog2(BOUNCE_EDGES) : 1;
   localparam logic [31:0]   BNC_END  = 32'(BOUNCE_CYC - 1);
   localparam logic [31:0]   GAP_END  = 32'(GAP_CYC - 1);
   localparam logic [EW-1:0] EDGE_END = EW'(BOUNCE_EDGES - 1);

   typedef enum logic [2:0] {
      IDLE,
      BNC_P,
      HOLD,
      BNC_R,
      GAP
   } state_t;

   state_t        state, state_d;
   logic [31:0]   cnt, cnt_d;
   logic [31:0]   hold_len, hold_d;
   logic [EW-1:0] edge_cnt, edge_d;
   logic [3:0]    key, key_d;
   logic          contact, contact_d;
   logic          done_d;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         hold_len <= '0;
         edge_cnt <= '0;
         key      <= '0;
         contact  <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         hold_len <= hold_d;
         edge_cnt <= edge_d;
         key      <= key_d;
         contact  <= contact_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      hold_d    = hold_len;
      edge_d    = edge_cnt;
      key_d     = key;
      contact_d = contact;
      done_d    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_d   = BNC_P;
               cnt_d     = '0;
               edge_d    = '0;
               contact_d = 1'b1;
               key_d     = cmd_key;
               hold_d    = 32'(cmd_hold_ms) * 32'(MS_CYC);
            end
         end
         BNC_P, BNC_R: begin
            if (cnt == BNC_END) begin
               cnt_d = '0;
               if (edge_cnt == EDGE_END) begin
                  edge_d = '0;
                  // zero hold skips straight from press to release bounce
                  if (state == BNC_R) begin
                     state_d   = GAP;
                     contact_d = 1'b0;
                  end else if (hold_len == 32'd0) begin
                     state_d   = BNC_R;
                     contact_d = 1'b0;
                  end else begin
                     state_d   = HOLD;
                     contact_d = 1'b1;
                  end
               end else begin
                  edge_d    = edge_cnt + 1'b1;
                  contact_d = ~contact;
               end
            end else begin
               cnt_d = cnt + 32'd1;
            end
         end
         HOLD: begin
            if (cnt == hold_len - 32'd1) begin
               cnt_d     = '0;
               state_d   = BNC_R;
               contact_d = 1'b0;
            end else begin
               cnt_d = cnt + 32'd1;
            end
         end
         GAP: begin
            if (cnt == GAP_END) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // combinational so the scanner sees the column in the same scan step
   always_comb begin
      col = 4'hF;
      if (contact && !row[key[3:2]])
         col[key[1:0]] = 1'b0;
   end

endmodule
